// File: rtl/fdtd_calc_ez_stream.sv
// fdtd_calc_ez_stream: streaming Ez update engine, the electric-field half of
// the 1-D FDTD leapfrog.
//   Ez_n[k] = ceze*Ez_old[k] + cezh*(Hy[k] - Hy[k-1])
// Cells 0..GRID_LEN-1 enter in order over a valid/ready stream.
// Results leave three cycles later, tagged with the cell index.
// The cells at both ends are PEC boundaries and always produce 0.
//
// Optional build macro FDTD_EZ_SAT_EN:
//   When it is defined, the Hy difference, the product slices and the final sum
//   saturate to the signed FDTD_DATA_WIDTH range instead of wrapping.
//
// Ports:
//   CLK, RST_N       clock; asynchronous active-low reset
//   clken            global enable; 0 freezes the pipeline and the FSM
//   start_i          starts a sweep (sampled in IDLE only)
//   in_valid_i/in_ready_o, Hy_i, Ez_old_i          input cell stream
//   ceze, cezh       update coefficients (1.0 = 2^CUT_RT)
//   out_valid_o/out_ready_i, Ez_n_o, out_idx_o     output cell stream
//   busy_o           high while the sweep is in RUN or DRAIN
//   done_o           one-cycle pulse at the end of a sweep
module fdtd_calc_ez_stream #(
  parameter int unsigned FDTD_DATA_WIDTH = 32,
  parameter int unsigned CUT_LT          = 51,
  parameter int unsigned CUT_RT          = 21,
  parameter int unsigned GRID_LEN        = 200,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       clken,
  input  logic                       start_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [FDTD_DATA_WIDTH-1:0] Hy_i,
  input  logic [FDTD_DATA_WIDTH-1:0] Ez_old_i,
  input  logic [FDTD_DATA_WIDTH-1:0] ceze,
  input  logic [FDTD_DATA_WIDTH-1:0] cezh,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [FDTD_DATA_WIDTH-1:0] Ez_n_o,
  output logic [CNT_W-1:0]           out_idx_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int unsigned W    = FDTD_DATA_WIDTH;
  localparam int unsigned PW   = 2 * W;
  // Product bits between the sign bit and the top of the kept slice.
  localparam int unsigned HI_W = PW - 2 - CUT_LT;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(GRID_LEN - 1);
  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_in_cnt;
  logic [CNT_W-1:0] r_out_cnt;
  logic [W-1:0]     r_hy_prev;

  logic             r_v1;
  logic [W-1:0]     r_diff;
  logic [W-1:0]     r_ez1;
  logic [CNT_W-1:0] r_idx1;
  logic             r_v2;
  logic [PW-1:0]    r_p0;
  logic [PW-1:0]    r_p1;
  logic [CNT_W-1:0] r_idx2;

  logic             w_adv;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [W-1:0]     w_diff;
  logic [PW-1:0]    w_p0;
  logic [PW-1:0]    w_p1;
  logic [W-1:0]     w_s0;
  logic [W-1:0]     w_s1;
  logic [W-1:0]     w_ez;
  logic             w_unused;

  // The whole pipeline moves only when enabled and the output is not stalled.
  assign w_adv      = clken & ~(out_valid_o & ~out_ready_i);
  assign in_ready_o = (r_state == S_RUN) & w_adv;
  assign w_in_fire  = in_valid_i & in_ready_o;
  assign w_out_fire = out_valid_o & out_ready_i & clken;

  // Full-width signed products, built from sign-extended operands.
  assign w_p0 = {{W{r_ez1[W-1]}}, r_ez1} * {{W{ceze[W-1]}}, ceze};
  assign w_p1 = {{W{r_diff[W-1]}}, r_diff} * {{W{cezh[W-1]}}, cezh};

`ifdef FDTD_EZ_SAT_EN
  function automatic logic [W-1:0] f_sat(input logic [W:0] s);
    logic [W-1:0] res;
    res = s[W-1:0];
    if (s[W] != s[W-1]) res = s[W] ? MIN_V : MAX_V;
    return res;
  endfunction

  assign w_diff = f_sat({Hy_i[W-1], Hy_i} - {r_hy_prev[W-1], r_hy_prev});
  // A slice is exact only when every bit above CUT_LT matches the sign.
  assign w_s0 = (r_p0[PW-2:CUT_LT+1] == {HI_W{r_p0[PW-1]}}) ?
                {r_p0[PW-1], r_p0[CUT_LT:CUT_RT]} : (r_p0[PW-1] ? MIN_V : MAX_V);
  assign w_s1 = (r_p1[PW-2:CUT_LT+1] == {HI_W{r_p1[PW-1]}}) ?
                {r_p1[PW-1], r_p1[CUT_LT:CUT_RT]} : (r_p1[PW-1] ? MIN_V : MAX_V);
  assign w_ez = f_sat({w_s0[W-1], w_s0} + {w_s1[W-1], w_s1});
`else
  assign w_diff = Hy_i - r_hy_prev;
  assign w_s0   = {r_p0[PW-1], r_p0[CUT_LT:CUT_RT]};
  assign w_s1   = {r_p1[PW-1], r_p1[CUT_LT:CUT_RT]};
  assign w_ez   = w_s0 + w_s1;
`endif

  // Product bits that are dropped by the slice.
  assign w_unused = ^{r_p0[PW-2:CUT_LT+1], r_p0[CUT_RT-1:0],
                      r_p1[PW-2:CUT_LT+1], r_p1[CUT_RT-1:0]};

  // Sweep FSM, cell counters and the Hy[k-1] history register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_hy_prev <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else if (clken) begin
      done_o <= 1'b0;
      if (w_in_fire) begin
        r_in_cnt  <= r_in_cnt + CNT_W'(1);
        r_hy_prev <= Hy_i;
      end
      if (w_out_fire) r_out_cnt <= r_out_cnt + CNT_W'(1);
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state   <= S_RUN;
            busy_o    <= 1'b1;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_hy_prev <= '0;
          end
        end
        S_RUN: begin
          if (w_in_fire && (r_in_cnt == LAST_IDX)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_out_fire && (r_out_cnt == LAST_IDX)) begin
            r_state <= S_DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Three-stage datapath: difference, products, slice-add with PEC forcing.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_v1        <= 1'b0;
      r_diff      <= '0;
      r_ez1       <= '0;
      r_idx1      <= '0;
      r_v2        <= 1'b0;
      r_p0        <= '0;
      r_p1        <= '0;
      r_idx2      <= '0;
      out_valid_o <= 1'b0;
      Ez_n_o      <= '0;
      out_idx_o   <= '0;
    end else if (w_adv) begin
      r_v1 <= w_in_fire;
      if (w_in_fire) begin
        r_diff <= w_diff;
        r_ez1  <= Ez_old_i;
        r_idx1 <= r_in_cnt;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_p0   <= w_p0;
        r_p1   <= w_p1;
        r_idx2 <= r_idx1;
      end
      out_valid_o <= r_v2;
      if (r_v2) begin
        Ez_n_o    <= ((r_idx2 == '0) || (r_idx2 == LAST_IDX)) ? '0 : w_ez;
        out_idx_o <= r_idx2;
      end
    end
  end

endmodule

// File: tb/tb_fdtd_calc_ez_stream.sv
// Scoreboard bench for fdtd_calc_ez_stream with GRID_LEN=8 and directed sweeps:
// basic, backpressure, clken pause, ignored start, saturation and reset mid-sweep.
module tb_fdtd_calc_ez_stream;
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned G  = 8;
  localparam logic [W-1:0] ONE  = 32'h0020_0000;
  localparam logic [W-1:0] HALF = 32'h0010_0000;

  logic          CLK, RST_N, clken, start_i;
  logic          in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic          busy_o, done_o;
  logic [W-1:0]  Hy_i, Ez_old_i, ceze, cezh, Ez_n_o;
  logic [CW-1:0] out_idx_o;

  typedef struct packed {
    logic [CW-1:0] idx;
    logic [W-1:0]  val;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] hy_v[G];
  logic [W-1:0] ez_v[G];
  logic [W-1:0] exp_v[G];
  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int n_done  = 0;
  int cyc     = 0;
  int first_acc = -1;
  int first_out = -1;
  logic [W-1:0]  hold_ez;
  logic [CW-1:0] hold_idx;
  logic          hold_v;

  fdtd_calc_ez_stream #(
    .FDTD_DATA_WIDTH(W), .CUT_LT(51), .CUT_RT(21), .GRID_LEN(G), .CNT_W(CW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .clken(clken), .start_i(start_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .Hy_i(Hy_i), .Ez_old_i(Ez_old_i), .ceze(ceze), .cezh(cezh),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .Ez_n_o(Ez_n_o), .out_idx_o(out_idx_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every output handshake.
  always @(negedge CLK) begin
    if (RST_N && clken && out_valid_o && out_ready_i) begin
      exp_t e;
      n_out++;
      if (first_out < 0) first_out = cyc;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got idx %0d val %h expected no output", out_idx_o, Ez_n_o);
      end else begin
        e = sb.pop_front();
        chk("out_idx", 64'(out_idx_o), 64'(e.idx));
        chk("out_val", 64'(Ez_n_o), 64'(e.val));
      end
    end
    if (done_o) n_done++;
  end

  task automatic begin_sweep();
    n_out = 0; n_done = 0; first_acc = -1; first_out = -1;
    start_i = 1'b1;
    @(posedge CLK); #1;
    start_i = 1'b0;
  endtask

  // Feeds n cells; expected results are queued at the accepting cycle.
  task automatic feed(input int n);
    for (int k = 0; k < n; k++) begin
      bit acc;
      int waited;
      acc = 1'b0; waited = 0;
      in_valid_i = 1'b1; Hy_i = hy_v[k]; Ez_old_i = ez_v[k];
      while (!acc) begin
        @(negedge CLK);
        if (in_ready_o) begin
          acc = 1'b1;
          sb.push_back('{idx: CW'(k), val: exp_v[k]});
          if (first_acc < 0) first_acc = cyc;
        end else if (++waited > 200) begin
          n_tests++; n_fail++;
          $display("FAIL accept_timeout: cell %0d not accepted in 200 cycles", k);
          in_valid_i = 1'b0;
          return;
        end
        @(posedge CLK); #1;
      end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic finish_sweep(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge CLK);
      if (done_o) found = 1'b1;
    end
    if (!found) begin
      n_tests++; n_fail++;
      $display("FAIL %s_done_timeout: done_o not seen in 300 cycles", name);
    end
    repeat (2) @(posedge CLK);
    #1;
    chk({name, "_n_out"}, 64'(n_out), 64'(G));
    chk({name, "_n_done"}, 64'(n_done), 64'd1);
    chk({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic load_basic();
    ceze = ONE; cezh = ONE;
    for (int k = 0; k < G; k++) begin
      hy_v[k]  = W'(10 * k);
      ez_v[k]  = W'(100);
      exp_v[k] = (k == 0 || k == G - 1) ? W'(0) : W'(110);
    end
  endtask

  // 0.5*(-200) + 1.0*(-5) = -105
  task automatic load_neg();
    ceze = HALF; cezh = ONE;
    for (int k = 0; k < G; k++) begin
      hy_v[k]  = W'(-5 * k);
      ez_v[k]  = W'(-200);
      exp_v[k] = (k == 0 || k == G - 1) ? W'(0) : 32'hFFFF_FF97;
    end
  endtask

  task automatic load_sat();
    ceze = ONE; cezh = ONE;
    for (int k = 0; k < G; k++) begin
      hy_v[k]  = (k == 0) ? W'(0) : 32'h0000_0100;
      ez_v[k]  = 32'h7FFF_FFF0;
      exp_v[k] = (k == 0 || k == G - 1) ? W'(0) : 32'h7FFF_FFF0;
    end
`ifdef FDTD_EZ_SAT_EN
    exp_v[1] = 32'h7FFF_FFFF;
`else
    exp_v[1] = 32'h8000_00F0;
`endif
  endtask

  task automatic backpressure();
    repeat (5) @(posedge CLK);
    #1;
    out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        hold_ez = Ez_n_o; hold_idx = out_idx_o;
        chk("bp_valid", 64'(out_valid_o), 64'd1);
      end else begin
        chk("bp_ez_stable", 64'(Ez_n_o), 64'(hold_ez));
        chk("bp_idx_stable", 64'(out_idx_o), 64'(hold_idx));
      end
      chk("bp_in_ready", 64'(in_ready_o), 64'd0);
    end
    @(posedge CLK); #1;
    out_ready_i = 1'b1;
  endtask

  task automatic clk_pause();
    repeat (5) @(posedge CLK);
    #1;
    clken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (i == 0) begin
        hold_ez = Ez_n_o; hold_idx = out_idx_o; hold_v = out_valid_o;
        chk("ck_busy", 64'(busy_o), 64'd1);
      end else begin
        chk("ck_ez_stable", 64'(Ez_n_o), 64'(hold_ez));
        chk("ck_idx_stable", 64'(out_idx_o), 64'(hold_idx));
        chk("ck_valid_stable", 64'(out_valid_o), 64'(hold_v));
      end
      chk("ck_in_ready", 64'(in_ready_o), 64'd0);
    end
    @(posedge CLK); #1;
    clken = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RST_N = 1'b0; clken = 1'b1; start_i = 1'b0; in_valid_i = 1'b0;
    out_ready_i = 1'b1; Hy_i = '0; Ez_old_i = '0; ceze = '0; cezh = '0;
    repeat (2) @(negedge CLK);
    chk("rst_in_ready", 64'(in_ready_o), 64'd0);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_ez", 64'(Ez_n_o), 64'd0);
    chk("rst_idx", 64'(out_idx_o), 64'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;

    load_basic(); begin_sweep(); feed(G); finish_sweep("basic");
    chk("basic_latency", 64'(first_out - first_acc), 64'd3);

    load_basic(); begin_sweep();
    fork feed(G); backpressure(); join
    finish_sweep("bp");

    load_neg(); begin_sweep();
    fork feed(G); clk_pause(); join
    finish_sweep("clken");

    load_basic(); begin_sweep();
    fork
      feed(G);
      begin
        repeat (3) @(posedge CLK);
        #1 start_i = 1'b1;
        @(posedge CLK);
        #1 start_i = 1'b0;
      end
    join
    finish_sweep("restart");

    load_sat(); begin_sweep(); feed(G); finish_sweep("sat");

    load_basic(); begin_sweep(); feed(3);
    RST_N = 1'b0;
    @(negedge CLK);
    chk("mid_rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("mid_rst_ez", 64'(Ez_n_o), 64'd0);
    chk("mid_rst_idx", 64'(out_idx_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    sb.delete();
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_in_ready", 64'(in_ready_o), 64'd0);
    @(posedge CLK); #1;
    begin_sweep(); feed(G); finish_sweep("clean");
    chk("clean_latency", 64'(first_out - first_acc), 64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
